// File: rtl/mult_host.sv
// mult_host: bus-master controller for the shift-add multiplier's shared
// parallel port.
//
// A request (req, a, b) accepted in IDLE is written to the multiplier over the
// bidirectional data bus (func 00 = M, func 01 = Q). The block then pulses
// startPB until ready falls, waits for ready to rise, and reads the product
// back in two halves (func 10 = low, func 11 = high). done pulses for one
// cycle at the end of every accepted request; err accompanies it when
// either ready-wait timed out.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   req, a, b        request and operands (sampled on acceptance)
//   busy, done, err  status; done is a one-cycle pulse, err is sticky
//   product          last good 2n-bit product
//   func, oe         multiplier function select / output enable
//   startPB, ready   multiplier start input / ready output
//   data             shared bus, driven here only while writing operands
module mult_host #(
  parameter int n       = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4194304
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*n-1:0] product,
  output logic [1:0]     func,
  output logic           oe,
  output logic           startPB,
  input  logic           ready,
  inout  wire  [n-1:0]   data
);

  // One counter serves both the settle phases and the ready-wait timeouts.
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_M, S_WR_Q, S_START, S_WAIT_HI, S_RD_LO, S_RD_HI, S_FIN
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [n-1:0]     a_reg, b_reg, low_reg;
  logic             err_reg;
  logic [2*n-1:0]   product_reg;

  logic             settled, timed_out, timeout_abort;
  logic             drive_en;
  logic [n-1:0]     drive_val;

  assign settled   = (cnt_reg == CW'(SETTLE - 1));
  assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    timeout_abort = 1'b0;
    func          = 2'b10;
    oe            = 1'b0;
    startPB       = 1'b0;
    drive_en      = 1'b0;
    drive_val     = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (req) state_next = S_WR_M;
      end
      S_WR_M: begin
        func      = 2'b00;
        drive_en  = 1'b1;
        drive_val = a_reg;
        if (settled) state_next = S_WR_Q;
      end
      S_WR_Q: begin
        func      = 2'b01;
        drive_en  = 1'b1;
        drive_val = b_reg;
        if (settled) state_next = S_START;
      end
      S_START: begin
        startPB = 1'b1;
        // A falling ready wins over a coincident timeout.
        if (!ready) begin
          state_next = S_WAIT_HI;
        end else if (timed_out) begin
          state_next    = S_FIN;
          timeout_abort = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (ready) begin
          state_next = S_RD_LO;
        end else if (timed_out) begin
          state_next    = S_FIN;
          timeout_abort = 1'b1;
        end
      end
      S_RD_LO: begin
        oe = 1'b1;
        if (settled) state_next = S_RD_HI;
      end
      S_RD_HI: begin
        func = 2'b11;
        oe   = 1'b1;
        if (settled) state_next = S_FIN;
      end
      S_FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      low_reg     <= '0;
      err_reg     <= 1'b0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Counter restarts on every state change, so each phase counts from 0.
      if (state_next != state_reg || state_reg == S_IDLE)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;

      if (state_reg == S_IDLE && req) begin
        a_reg   <= a;
        b_reg   <= b;
        err_reg <= 1'b0;
      end
      if (timeout_abort)
        err_reg <= 1'b1;
      if (state_reg == S_RD_LO && settled)
        low_reg <= data;
      // Both halves land together so product never shows a partial update.
      if (state_reg == S_RD_HI && settled)
        product_reg <= {data, low_reg};
    end
  end

  assign err     = err_reg;
  assign product = product_reg;

  // Per-bit tristate drivers; released whenever not writing an operand.
  for (genvar gi = 0; gi < n; gi++) begin : g_bus
    assign data[gi] = drive_en ? drive_val[gi] : 1'bz;
  end

endmodule

// File: tb/tb_mult_host.sv
// Self-checking bench for mult_host with a behavioural multiplier on the
// shared bus. The multiplier latches M/Q from the bus under func 00/01,
// drops ready LS cycles after seeing startPB and raises it LR cycles later,
// and drives the product halves while oe=1. Modes allow ready to stick high
// or low so both timeouts are reached.
module tb_mult_host;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int TO = 64;
  localparam int LS = 3;
  localparam int LR = 10;

  logic          clock, reset, req;
  logic [N-1:0]  a, b;
  logic          busy, done, err;
  logic [2*N-1:0] product;
  logic [1:0]    func;
  logic          oe, startPB, ready;
  wire  [N-1:0]  data;

  mult_host #(.n(N), .SETTLE(S), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .product(product),
    .func(func), .oe(oe), .startPB(startPB), .ready(ready), .data(data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural multiplier ----------------
  int            mode;      // 0 normal, 1 ready stuck high, 2 ready stuck low
  int            phase, mcnt;
  logic [N-1:0]  m_lat, q_lat;
  logic [2*N-1:0] mprod;
  assign mprod = (2*N)'(m_lat) * (2*N)'(q_lat);
  assign data  = oe ? (func == 2'b11 ? mprod[2*N-1:N] : mprod[N-1:0]) : {N{1'bz}};

  always @(posedge clock) begin
    if (reset || done) begin
      phase <= 0;
      mcnt  <= 0;
      ready <= 1'b1;
    end else begin
      if (!oe && func == 2'b00) m_lat <= data;
      if (!oe && func == 2'b01) q_lat <= data;
      case (phase)
        0: if (startPB && mode != 1) begin phase <= 1; mcnt <= LS - 2; end
        1: if (mcnt == 0) begin ready <= 1'b0; phase <= 2; mcnt <= LR - 1; end
           else mcnt <= mcnt - 1;
        2: if (mode != 2) begin
             if (mcnt == 0) begin ready <= 1'b1; phase <= 3; end
             else mcnt <= mcnt - 1;
           end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  logic [N-1:0]   pa, pb;      // operands of the pending request
  logic           perr;        // pending request expected to time out
  int             plat;        // expected busy cycles for pending request
  logic [2*N-1:0] mdl_product;
  logic           mdl_err;
  int             busy_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      mdl_product = '0;
      mdl_err     = 1'b0;
      busy_cycles = 0;
    end else begin
      if (oe) check("func_under_oe", 32'(func[1]), 32'd1);
      if (!oe && func == 2'b00) check("bus_wr_m", 32'(data), 32'(pa));
      if (!oe && func == 2'b01) check("bus_wr_q", 32'(data), 32'(pb));
      if (busy) begin
        busy_cycles++;
        check("err_while_busy", 32'(err), 32'd0);
      end
      if (done) begin
        logic [2*N-1:0] exp_p;
        exp_p = perr ? mdl_product : (2*N)'(pa) * (2*N)'(pb);
        check("done_product", 32'(product), 32'(exp_p));
        check("done_err", 32'(err), 32'(perr));
        check("done_startpb", 32'(startPB), 32'd0);
        check("done_oe", 32'(oe), 32'd0);
        check("latency", busy_cycles, plat);
        mdl_product = exp_p;
        mdl_err     = perr;
        busy_cycles = 0;
      end else begin
        check("product_held", 32'(product), 32'(mdl_product));
        if (!busy) check("err_held", 32'(err), 32'(mdl_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!busy && !done) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept(input logic [N-1:0] x, input logic [N-1:0] y, input int md);
    wait_idle();
    mode = md;
    pa   = x;
    pb   = y;
    perr = (md != 0);
    plat = (md == 0) ? 4*S + LS + LR + 1 : (md == 1) ? 2*S + TO : 2*S + LS + 1 + TO;
    a    = x;
    b    = y;
    req  = 1'b1;
    @(posedge clock);
    #1 req = 1'b0;
  endtask

  task automatic do_req(input logic [N-1:0] x, input logic [N-1:0] y, input int md,
                        input logic use_lit, input logic [2*N-1:0] lit_p, input logic lit_e);
    logic got;
    accept(x, y, md);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    else if (use_lit) begin
      check("lit_product", 32'(product), 32'(lit_p));
      check("lit_err", 32'(err), 32'(lit_e));
    end
    $display("req a=0x%02h b=0x%02h mode=%0d -> product=0x%04h err=%0d", x, y, md, product, err);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; req = 1'b0; a = '0; b = '0; mode = 0;
    pa = '0; pb = '0; perr = 1'b0; plat = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_func", 32'(func), 32'd2);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_startpb", 32'(startPB), 32'd0);
    reset = 1'b0;

    do_req(8'd13, 8'd11, 0, 1'b1, 16'h008F, 1'b0);
    do_req(8'hFF, 8'hFF, 0, 1'b1, 16'hFE01, 1'b0);
    do_req(8'h00, 8'h55, 0, 1'b1, 16'h0000, 1'b0);
    do_req(8'h12, 8'h34, 0, 1'b1, 16'h03A8, 1'b0);
    do_req(8'h21, 8'h03, 1, 1'b1, 16'h03A8, 1'b1);   // ready stuck high
    do_req(8'h05, 8'h05, 0, 1'b1, 16'h0019, 1'b0);   // clears err
    do_req(8'h03, 8'h03, 2, 1'b1, 16'h0019, 1'b1);   // ready stuck low

    for (int i = 0; i < 100; i++)
      do_req(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 0, 1'b0, '0, 1'b0);

    // Reset during WAIT_HI: wait for startPB to rise and then fall.
    accept(8'h09, 8'h09, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (startPB) seen = 1'b1;
      else if (seen) break;
    end
    check("reached_wait_hi", 32'(seen && busy && !startPB), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_product", 32'(product), 32'd0);
    check("mid_func", 32'(func), 32'd2);
    check("mid_oe", 32'(oe), 32'd0);
    check("mid_startpb", 32'(startPB), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("no_done_after_reset", 32'(done), 32'd0);
    end

    do_req(8'd7, 8'd6, 0, 1'b1, 16'h002A, 1'b0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mult_host.md
# mult_host

Bus-master controller for the shift-add multiplier's shared parallel port. It takes two n-bit operands through a request/done handshake and loads them over the bidirectional data bus (func 00 then 01). It then drives the start input, waits for the multiplier's ready to fall and rise again, and reads back the low and high product halves (func 10, 11). It sits between the board-level test logic and the multiplier, so the multiplier's port protocol is exercised from the initiator side.

## Interface

Parameters:
- n, 8: operand width; the product is 2n bits.
- SETTLE, 2: cycles each bus phase (write or read) is held before advancing or sampling; minimum 1.
- TIMEOUT, 4194304: maximum cycles spent in either ready-wait state before aborting. Default covers the 1M-cycle start debounce.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request; accepted only when busy=0
- a  in  n  multiplicand (M), sampled on acceptance
- b  in  n  multiplier (Q), sampled on acceptance
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse; ends every accepted request
- err  out  1  set with done on timeout; cleared on next acceptance
- product  out  2n  last good product; held between requests
- func  out  2  multiplier function select
- oe  out  1  multiplier output enable
- startPB  out  1  multiplier start input
- ready  in  1  multiplier ready
- data  inout  n  shared bus; driven by this block only in WR_M and WR_Q

## Operation

- Reset values: busy=0, done=0, err=0, product=0, func=2'b10, oe=0, startPB=0, data=Z, state IDLE. Reset mid-operation aborts on the next edge; no done pulse.
- The idle bus state is func=10, oe=0. In this state the multiplier neither latches nor drives.
- States and outputs:
  - IDLE: idle bus. req=1 latches a and b, clears err, sets busy, and goes to WR_M.
  - WR_M: data=a, func=00, oe=0 for SETTLE cycles, then WR_Q.
  - WR_Q: data=b, func=01, oe=0 for SETTLE cycles, then START. Data is released (Z) on exit.
  - START: func=10, oe=0, startPB=1. Goes to WAIT_HI when ready=0 is sampled. Timeout applies.
  - WAIT_HI: startPB=0. Goes to RD_LO when ready=1 is sampled. Timeout applies.
  - RD_LO: func=10, oe=1, data=Z. On the SETTLE-th cycle, data is captured into a low-half holding register; then RD_HI.
  - RD_HI: func=11, oe=1. On the SETTLE-th cycle, product is loaded from {data, low half} in a single update; then FIN.
  - FIN: idle bus (oe=0), done=1 for exactly this cycle, busy=0, then IDLE.
- Timeout:
  - A cycle counter is cleared on entry to START and to WAIT_HI.
  - If it reaches TIMEOUT-1 without the exit condition, the next state is FIN with err=1.
  - product is unchanged on timeout; startPB drops to 0 on that transition.
- Bus-safety invariants:
  - Never drive data while oe=1.
  - At least one cycle with oe=0 and data=Z separates any read phase from the next write. FIN plus IDLE guarantee this.
  - func never takes 00 or 01 while oe=1.
- req while busy=1 is ignored; no queuing. req in the same cycle as FIN is ignored; it is accepted only from IDLE.
- product is updated only on successful completion; there is no partial update.

## Timing

- Acceptance edge E0: the state becomes WR_M on E0, and busy=1 in the cycle after E0.
- WR_M occupies cycles 1..SETTLE. WR_Q occupies SETTLE+1..2·SETTLE. startPB rises in cycle 2·SETTLE+1.
- startPB falls one cycle after ready=0 is sampled. RD_LO begins one cycle after ready=1 is sampled.
- Read: RD_LO and RD_HI take SETTLE cycles each. product is valid in the FIN cycle, coincident with done.
- Total latency with multiplier latencies Ls (startPB high until ready low) and Lr (ready low until ready high): 4·SETTLE + Ls + Lr + 1 cycles from acceptance to done.
- A back-to-back request is accepted at the earliest in the cycle after FIN.

## Test plan

Bench settings: n=8, SETTLE=2, TIMEOUT=64. The behavioural multiplier model drops ready 3 cycles after startPB and raises it 10 cycles later.

- Basic multiply: a=13, b=11 -> bus shows 0x0D under func=00, then 0x0B under func=01; done pulses once; product=0x008F; err=0; latency matches the formula.
- Maximum operands: a=0xFF, b=0xFF -> product=0xFE01. Follow immediately with a=0, b=0x55 -> product=0x0000, and the previous value is held until that done.
- Timeout, ready stuck: ready held at 1 -> after 64 cycles in START, done=1, err=1, startPB=0, product unchanged. A following good request clears err.
- Timeout in WAIT_HI: ready falls but never rises -> abort after 64 cycles in WAIT_HI, err=1.
- Contention check: a bus monitor flags any cycle where the block drives data while oe=1, and any cycle where func∈{00,01} while oe=1 -> zero violations over 100 random-operand requests, all checked against a×b.
- Reset mid-operation: assert reset during WAIT_HI -> next edge gives all outputs at reset values, data=Z, no done. A subsequent a=7, b=6 request yields product=0x002A.
